// File: rtl/add_pipe_if.sv
// Operand/result handshake bundle for add_pipe.
// The producer side drives operands and out_ready; the adder drives the rest.
interface add_pipe_if #(
   parameter int DATAWIDTH = 8
) ();
   logic [DATAWIDTH-1:0] a;
   logic [DATAWIDTH-1:0] b;
   logic                 sub;
   logic                 in_valid;
   logic                 in_ready;
   logic [DATAWIDTH-1:0] sum;
   logic                 cout;
   logic                 ovf;
   logic                 out_valid;
   logic                 out_ready;

   modport master (
      output a, b, sub, in_valid, out_ready,
      input  in_ready, sum, cout, ovf, out_valid
   );

   modport slave (
      input  a, b, sub, in_valid, out_ready,
      output in_ready, sum, cout, ovf, out_valid
   );
endinterface

// File: rtl/add_pipe.sv
// add_pipe: ripple adder/subtractor cut into STAGES carry slices, one per
// pipeline stage, with valid/ready flow control, overflow and saturation.
module add_pipe #(
   parameter int DATAWIDTH = 8,
   parameter int STAGES    = 2,
   parameter bit SIGNED    = 1'b0,
   parameter bit SATURATE  = 1'b0
) (
   input  logic      Clk,
   input  logic      Rst,
   add_pipe_if.slave bus
);

   localparam int W = DATAWIDTH / STAGES;
   localparam int L = STAGES - 1;

   logic                 en;
   logic [DATAWIDTH-1:0] bx;

   logic [W-1:0]         fa;
   logic [W-1:0]         fb;
   logic                 fc;
   logic                 fv;
   logic                 fs;
   logic [W:0]           fsl;
   logic [DATAWIDTH-1:0] res;
   logic [DATAWIDTH-1:0] satv;
   logic [DATAWIDTH-1:0] sum_d;
   logic                 ovf_u;
   logic                 ovf_s;
   logic                 ovf_d;

   logic [DATAWIDTH-1:0] sum_q;
   logic                 cout_q;
   logic                 ovf_q;
   logic                 vld_q;

   assign en           = !vld_q | bus.out_ready;
   assign bus.in_ready = en;
   assign bx           = bus.sub ? ~bus.b : bus.b;

   // Each stage keeps only the operand slices still to be added and the
   // result slices already produced, so every bit of one op moves together.
   for (genvar k = 0; k < L; k++) begin : g_stage
      localparam int SW = DATAWIDTH - k * W;
      localparam int HW = SW - W;
      localparam int LW = (k + 1) * W;

      logic [SW-1:0] sa;
      logic [SW-1:0] sb;
      logic          cin;
      logic          vin;
      logic          sin;
      logic [W:0]    sl;
      logic [LW-1:0] lo_d;
      logic [LW-1:0] lo_q;
      logic [HW-1:0] ha_q;
      logic [HW-1:0] hb_q;
      logic          c_q;
      logic          s_q;
      logic          v_q;

      if (k == 0) begin : g_head
         assign sa   = bus.a;
         assign sb   = bx;
         assign cin  = bus.sub;
         assign vin  = bus.in_valid;
         assign sin  = bus.sub;
         assign lo_d = sl[W-1:0];
      end else begin : g_body
         assign sa   = g_stage[k-1].ha_q;
         assign sb   = g_stage[k-1].hb_q;
         assign cin  = g_stage[k-1].c_q;
         assign vin  = g_stage[k-1].v_q;
         assign sin  = g_stage[k-1].s_q;
         assign lo_d = {sl[W-1:0], g_stage[k-1].lo_q};
      end

      assign sl = {1'b0, sa[W-1:0]}
                + {1'b0, sb[W-1:0]}
                + {{W{1'b0}}, cin};

      always_ff @(posedge Clk or negedge Rst) begin
         if (!Rst) begin
            ha_q <= '0;
            hb_q <= '0;
            lo_q <= '0;
            c_q  <= 1'b0;
            s_q  <= 1'b0;
            v_q  <= 1'b0;
         end else if (en) begin
            ha_q <= sa[SW-1:W];
            hb_q <= sb[SW-1:W];
            lo_q <= lo_d;
            c_q  <= sl[W];
            s_q  <= sin;
            v_q  <= vin;
         end
      end
   end

   if (L == 0) begin : g_tail1
      assign fa  = bus.a;
      assign fb  = bx;
      assign fc  = bus.sub;
      assign fv  = bus.in_valid;
      assign fs  = bus.sub;
      assign res = fsl[W-1:0];
   end else begin : g_tailn
      assign fa  = g_stage[L-1].ha_q;
      assign fb  = g_stage[L-1].hb_q;
      assign fc  = g_stage[L-1].c_q;
      assign fv  = g_stage[L-1].v_q;
      assign fs  = g_stage[L-1].s_q;
      assign res = {fsl[W-1:0], g_stage[L-1].lo_q};
   end

   assign fsl = {1'b0, fa} + {1'b0, fb} + {{W{1'b0}}, fc};

   // fb is already inverted for subtract, so one sign rule covers both ops.
   assign ovf_u = fs ? !fsl[W] : fsl[W];
   assign ovf_s = (fa[W-1] == fb[W-1])
                & (res[DATAWIDTH-1] != fa[W-1]);
   assign ovf_d = SIGNED ? ovf_s : ovf_u;

   always_comb begin
      satv = fs ? '0 : '1;
      if (SIGNED) begin
         satv = fa[W-1]
              ? {1'b1, {(DATAWIDTH-1){1'b0}}}
              : {1'b0, {(DATAWIDTH-1){1'b1}}};
      end
   end

   assign sum_d = (SATURATE && ovf_d) ? satv : res;

   always_ff @(posedge Clk or negedge Rst) begin
      if (!Rst) begin
         sum_q  <= '0;
         cout_q <= 1'b0;
         ovf_q  <= 1'b0;
         vld_q  <= 1'b0;
      end else if (en) begin
         sum_q  <= sum_d;
         cout_q <= fsl[W];
         ovf_q  <= ovf_d;
         vld_q  <= fv;
      end
   end

   assign bus.sum       = sum_q;
   assign bus.cout      = cout_q;
   assign bus.ovf       = ovf_q;
   assign bus.out_valid = vld_q;

endmodule
